// File: rtl/pmp_pkg.sv
// Shared PMP definitions: CSR map, cfg byte layout, encodings and the region descriptor.
package pmp_pkg;

  localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

  // pmpcfg byte bit positions
  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  typedef enum logic [1:0] {A_OFF = 2'd0, A_TOR = 2'd1, A_NA4 = 2'd2, A_NAPOT = 2'd3} pmp_a_e;

  typedef enum logic [1:0] {ERR_OK = 2'd0, ERR_LOCKED = 2'd1, ERR_RANGE = 2'd2} pmp_err_e;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CFG, S_RD_PREV, S_WR_LO, S_WR_HI, S_WR_CFG, S_RESP
  } pmp_state_e;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] base;
    logic [31:0] top;
    logic [2:0]  perm;
    logic        lock;
  } pmp_region_t;

  // Pull byte b out of a pmpcfg word.
  function automatic logic [7:0] cfg_byte(input logic [31:0] w, input logic [1:0] b);
    return w[{b, 3'b000} +: 8];
  endfunction

  // Build a TOR cfg byte; perm is {X,W,R}.
  function automatic logic [7:0] tor_cfg(input logic lock, input logic [2:0] perm);
    logic [7:0] c;
    c                    = '0;
    c[CFG_L]             = lock;
    c[CFG_A_HI:CFG_A_LO] = A_TOR;
    c[CFG_X:CFG_R]       = perm;
    return c;
  endfunction

endpackage

// File: rtl/pmp_cfg_byte_merge.sv
// Replace one byte of a pmpcfg word, leaving the other three untouched.
module pmp_cfg_byte_merge (
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_idx_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o
);

  // Overlay the new byte onto the original word
  always_comb begin
    word_o = word_i;
    word_o[{byte_idx_i, 3'b000} +: 8] = byte_i;
  end

endmodule

// File: rtl/pmp_tor_programmer.sv
// Sequencer that programs a PMP TOR region: read cfg words, check locks,
// write lower bound, upper bound, then the cfg byte last.
module pmp_tor_programmer
  import pmp_pkg::*;
#(
  parameter int PMP_ENTRIES = 16,
  parameter int XLEN        = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [$clog2(PMP_ENTRIES)-1:0] req_idx,
  input  logic [XLEN-1:0]                req_base,
  input  logic [XLEN-1:0]                req_top,
  input  logic [2:0]                     req_perm,
  input  logic                           req_lock,
  output logic                           rsp_valid,
  output logic [1:0]                     rsp_err,
  output logic                           csr_req,
  output logic                           csr_we,
  output logic [11:0]                    csr_addr,
  output logic [XLEN-1:0]                csr_wdata,
  input  logic [XLEN-1:0]                csr_rdata,
  input  logic                           csr_ack
);

  pmp_state_e  state_q, state_d;
  pmp_region_t reg_q, reg_d;
  pmp_err_e    rsp_err_q, rsp_err_d;
  logic [31:0] cfg_q, cfg_d, csr_wdata_q, csr_wdata_d, merged_word;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic        csr_req_q, csr_req_d, csr_we_q, csr_we_d, rsp_valid_q, rsp_valid_d;
  logic        ack, range_bad;
  logic [3:0]  idx_prev;
  logic [7:0]  rd_own_byte, held_own_byte, rd_prev_byte, new_byte;

  assign ack           = csr_req_q & csr_ack;
  assign idx_prev      = reg_q.idx - 4'd1;
  assign rd_own_byte   = cfg_byte(csr_rdata, reg_q.idx[1:0]);
  assign held_own_byte = cfg_byte(cfg_q, reg_q.idx[1:0]);
  assign rd_prev_byte  = cfg_byte(csr_rdata, idx_prev[1:0]);
  assign new_byte      = tor_cfg(reg_q.lock, reg_q.perm);

  // Entry 0 has an implicit bottom of 0, so any other base is unrepresentable
  assign range_bad = (req_base[1:0] != 2'b00) || (req_top[1:0] != 2'b00) ||
                     (req_base >= req_top) || ((req_idx == 4'd0) && (req_base != 32'd0));

  pmp_cfg_byte_merge u_merge (
    .word_i     (cfg_q),
    .byte_idx_i (reg_q.idx[1:0]),
    .byte_i     (new_byte),
    .word_o     (merged_word)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    reg_d       = reg_q;
    cfg_d       = cfg_q;
    csr_req_d   = csr_req_q;
    csr_we_d    = csr_we_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        reg_d = '{idx: req_idx, base: req_base, top: req_top, perm: req_perm, lock: req_lock};
        if (range_bad) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_RANGE;
        end else begin
          state_d    = S_RD_CFG;
          csr_req_d  = 1'b1;
          csr_we_d   = 1'b0;
          csr_addr_d = CSR_PMPCFG0 + {10'd0, req_idx[3:2]};
        end
      end
      S_RD_CFG: if (ack) begin
        cfg_d = csr_rdata;
        if (reg_q.idx != 4'd0) begin
          state_d    = S_RD_PREV;
          csr_addr_d = CSR_PMPCFG0 + {10'd0, idx_prev[3:2]};
        end else if (rd_own_byte[CFG_L]) begin
          state_d     = S_RESP;
          csr_req_d   = 1'b0;
          csr_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_LOCKED;
        end else begin
          state_d     = S_WR_HI;
          csr_we_d    = 1'b1;
          csr_addr_d  = CSR_PMPADDR0 + {8'd0, reg_q.idx};
          csr_wdata_d = {2'b00, reg_q.top[31:2]};
        end
      end
      S_RD_PREV: if (ack) begin
        if (held_own_byte[CFG_L] || rd_prev_byte[CFG_L]) begin
          state_d     = S_RESP;
          csr_req_d   = 1'b0;
          csr_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_LOCKED;
        end else begin
          state_d     = S_WR_LO;
          csr_we_d    = 1'b1;
          csr_addr_d  = CSR_PMPADDR0 + {8'd0, idx_prev};
          csr_wdata_d = {2'b00, reg_q.base[31:2]};
        end
      end
      S_WR_LO: if (ack) begin
        state_d     = S_WR_HI;
        csr_addr_d  = CSR_PMPADDR0 + {8'd0, reg_q.idx};
        csr_wdata_d = {2'b00, reg_q.top[31:2]};
      end
      S_WR_HI: if (ack) begin
        state_d     = S_WR_CFG;
        csr_addr_d  = CSR_PMPCFG0 + {10'd0, reg_q.idx[3:2]};
        csr_wdata_d = merged_word;
      end
      S_WR_CFG: if (ack) begin
        state_d     = S_RESP;
        csr_req_d   = 1'b0;
        csr_we_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = ERR_OK;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      reg_q       <= '0;
      cfg_q       <= '0;
      csr_req_q   <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      reg_q       <= reg_d;
      cfg_q       <= cfg_d;
      csr_req_q   <= csr_req_d;
      csr_we_q    <= csr_we_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign csr_req   = csr_req_q;
  assign csr_we    = csr_we_q;
  assign csr_addr  = csr_addr_q;
  assign csr_wdata = csr_wdata_q;

endmodule

// File: doc/pmp_tor_programmer.md
# pmp_tor_programmer

- Write-side sequencer for PMP TOR regions, the producer of the `pmpaddr[n-1]`/`pmpaddr[n]` pair and `pmpcfg` byte that the TOR matcher consumes.
- Accepts one region descriptor per transaction and checks range and lock rules.
- Emits the CSR read/read/write/write/write sequence on a simple request/acknowledge CSR port, then returns a one-cycle status.
- Sits between the machine-mode configuration master (boot ROM sequencer or debug module) and the PMP CSR file.

## Interface
Parameters:
- `PMP_ENTRIES`, 16, number of PMP entries; only 16 is supported, so `req_idx` is 4 bits.
- `XLEN`, 32, CSR data width.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  region request present
- `req_ready`  out  1  high only in IDLE
- `req_idx`  in  4  TOR entry n
- `req_base`  in  32  region bottom, byte address, inclusive
- `req_top`  in  32  region top, byte address, exclusive
- `req_perm`  in  3  {X,W,R}
- `req_lock`  in  1  set the L bit of entry n
- `rsp_valid`  out  1  one-cycle completion pulse, no backpressure
- `rsp_err`  out  2  0 OK, 1 LOCKED, 2 RANGE
- `csr_req`  out  1  CSR access request
- `csr_we`  out  1  1 write, 0 read
- `csr_addr`  out  12  CSR address
- `csr_wdata`  out  32  write data
- `csr_rdata`  in  32  read data, valid when `csr_req && csr_ack`
- `csr_ack`  in  1  access completes this cycle

## Operation
- **Accept.** The request is latched on `req_valid && req_ready`.
- **RANGE check (at accept).** RANGE if any of:
  - `base[1:0]` or `top[1:0]` is nonzero;
  - `base >= top` (unsigned);
  - `idx == 0` and `base != 0`.
- **RANGE result.** Go directly to RESP with no CSR traffic.
- **CSR map.**
  - `pmpcfgK` = 0x3A0+K, where K = idx[3:2]; entry byte = idx[1:0].
  - `pmpaddrN` = 0x3B0+N.
  - Address fields are written as `addr >> 2`.
- **Cfg byte.** L=bit7, A=bits4:3 (TOR=2'b01), X=bit2, W=bit1, R=bit0.
- **FSM states:** IDLE, RD_CFG, RD_PREV, WR_LO, WR_HI, WR_CFG, RESP.
  - RD_CFG reads `pmpcfg[idx>>2]` and holds the word.
  - RD_PREV reads `pmpcfg[(idx-1)>>2]`. It is skipped when idx==0. It is issued even when it is the same register as RD_CFG.
  - After the reads, LOCKED if `cfg[idx].L` or (idx>0 and `cfg[idx-1].L`). LOCKED goes to RESP with no writes.
  - WR_LO writes `pmpaddr[idx-1] = base>>2`. It is skipped when idx==0.
  - WR_HI writes `pmpaddr[idx] = top>>2`.
  - WR_CFG writes the held RD_CFG word with byte idx[1:0] replaced by {lock,2'b00,2'b01,perm}. All other bytes are unchanged.
  - RESP drives `rsp_valid=1` and `rsp_err`, then returns to IDLE.
- **State advance.** Each CSR state advances only on `csr_req && csr_ack`.
- **Write ordering.** The cfg write is always last, so the region is never enabled with partially written bounds.

## Timing
- **Reset values:**
  - `req_ready=1`, `rsp_valid=0`, `rsp_err=0`;
  - `csr_req=0`, `csr_we=0`, `csr_addr=0`, `csr_wdata=0`;
  - FSM in IDLE.
- **CSR handshake.**
  - `csr_req`, `csr_we`, `csr_addr` and `csr_wdata` are registered.
  - They are stable from assertion until the ack cycle.
  - Same-cycle ack is legal.
  - The next access is asserted on the cycle after the ack. `csr_req` is low for at least one cycle only on entry to RESP/IDLE.
- **Latency with zero-wait ack (accept = cycle 0):**
  - idx>0, OK: cycles 1–5 are CSR accesses; `rsp_valid` in cycle 6.
  - idx==0: cycles 1–3 are CSR accesses; `rsp_valid` in cycle 4.
  - RANGE: `rsp_valid` in cycle 1.
  - LOCKED: `rsp_valid` in cycle 3 (cycle 2 when idx==0).
- **Back-to-back.** `req_ready` rises the cycle after RESP, so the minimum request spacing is latency+1.
- **`req_valid` while busy** is ignored. The latched request is not modified.
- **Reset mid-operation.**
  - Asynchronous return to IDLE; `csr_req` drops immediately.
  - The in-flight access is abandoned and no `rsp_valid` is produced.
  - Partially written `pmpaddr` values remain. This is legal because A was not yet written.
- **Arithmetic.** `top = 0xFFFFFFFC` is legal.

## Structure
- **`pmp_pkg`** holds:
  - `CSR_PMPCFG0` (0x3A0) and `CSR_PMPADDR0` (0x3B0);
  - the cfg bit positions;
  - the A-field enum (OFF, TOR, NA4, NAPOT);
  - the `rsp_err` enum;
  - the FSM state enum;
  - `pmp_region_t` (idx, base, top, perm, lock).
- **`pmp_cfg_byte_merge`** is one combinational sub-module: word + byte index + new byte → merged word. It is reused by the CSR file.

## Test plan
1. **Basic TOR write.** idx=2, base 0x1000, top 0x2000, perm=3'b011, lock=0, `pmpcfg0` reads 0x00000000.
   → reads 0x3A0 and 0x3A0.
   → writes 0x3B1←0x400, 0x3B2←0x800, 0x3A0←0x000B0000.
   → rsp_err=OK in cycle 6.
2. **Entry 0, locked.** idx=0, base 0, top 0x100, perm=3'b100, lock=1, `pmpcfg0` reads 0x11223300.
   → single read of 0x3A0.
   → writes 0x3B0←0x40, 0x3A0←0x1122338C.
   → OK in cycle 4.
3. **Lock on previous entry across cfg registers.** idx=4, `pmpcfg1` reads 0, `pmpcfg0` reads 0x80000000.
   → reads 0x3A1 then 0x3A0.
   → LOCKED, zero writes.
4. **RANGE rejection.** Three requests: base=top=0x2000; base=0x1002; idx=0 with base 0x10.
   → each gives RANGE in cycle 1 with `csr_req` never asserted.
5. **Slow ack and mid-operation reset.** Ack delayed 3 cycles on every access.
   → `csr_addr`/`csr_wdata` stable throughout; latency grows by 3 per access.
   Repeat with `rst_n` pulsed low during WR_HI.
   → all outputs at reset values, no `rsp_valid`.
   → `req_ready=1` after release, and a new request completes normally.
